// File: rtl/spi_cfg_cdc.sv
// spi_cfg_cdc
//
// Carries a packed configuration word from the AXI configuration domain (clk) into the SPI core
// domain (spi_clk) as one coherent multi-bit transfer.
//
// Source side (clk):
//   The incoming word is debounced. It must be seen unchanged on STABLE_COUNT consecutive clk
//   edges before it is launched. At launch the word is frozen in a holding register and the
//   request toggle flips. No further launch happens until the acknowledge toggle returns through
//   its synchronizer, so the holding register is static while the far side samples it.
//   A word that settles during a transfer waits for the transfer to end. Intermediate values are
//   lost and the latest stable value wins.
//
// Destination side (spi_clk):
//   The synchronized request toggle marks an arrival. The word is copied into a staging register
//   and acknowledged. The staged word is applied to cfg_out when apply_en allows it: at once in
//   UPDATE_MODE 0, or only on apply_strobe in UPDATE_MODE 1.
//
// Ports:
//   spi_clk      destination clock
//   clk          source (AXI) clock
//   rst          asynchronous active-high reset for both domains
//   cfg_in       packed configuration word (clk domain)
//   src_busy     transfer in flight (clk domain)
//   apply_en     apply permitted (spi_clk domain)
//   apply_strobe apply point when UPDATE_MODE = 1 (spi_clk domain)
//   cfg_out      applied configuration word
//   cfg_valid    sticky: a word has been applied since reset
//   cfg_pending  a staged word is waiting to be applied
//   cfg_update   one-cycle pulse coinciding with a new cfg_out value
//   cfg_dropped  one-cycle pulse when a pending staged word is overwritten unapplied

module spi_cfg_cdc #(
  parameter int unsigned      WIDTH        = 128,
  parameter int unsigned      SYNC_DEPTH   = 3,
  parameter int unsigned      STABLE_COUNT = 2,
  parameter int unsigned      UPDATE_MODE  = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
  input  logic             spi_clk,
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_in,
  output logic             src_busy,
  input  logic             apply_en,
  input  logic             apply_strobe,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             cfg_pending,
  output logic             cfg_update,
  output logic             cfg_dropped
);

  localparam int unsigned    CntW         = $clog2(STABLE_COUNT + 1);
  localparam logic [CntW-1:0] StableMax    = CntW'(STABLE_COUNT);
  // The launching edge is the one on which the count would reach STABLE_COUNT.
  localparam logic [CntW-1:0] StableLaunch = CntW'(STABLE_COUNT - 1);
  localparam bit             StrobeMode   = (UPDATE_MODE != 0);

  // ---------------------------------------------------------------------------------------------
  // Source domain (clk)
  // ---------------------------------------------------------------------------------------------

  logic [WIDTH-1:0]      cfg_in_q;    // cfg_in delayed by one clk edge
  logic [WIDTH-1:0]      src_last_q;  // last launched word
  logic [WIDTH-1:0]      hold_q;      // word presented to the destination
  logic [CntW-1:0]       stab_cnt_q;
  logic [CntW-1:0]       stab_cnt_d;
  logic                  armed_q;     // low until the first launch after reset
  logic                  req_tgl_q;
  logic                  busy_q;
  logic                  busy_d;
  logic [SYNC_DEPTH-1:0] ack_sync_q;
  logic                  ack_s;

  logic                  in_changed;
  logic                  candidate;
  logic                  launch;

  // Driven by the destination domain.
  logic                  ack_tgl_q;

  assign ack_s = ack_sync_q[SYNC_DEPTH-1];

  always_comb begin
    in_changed = (cfg_in != cfg_in_q);
    // A word equal to the last launched one is not resent, except before the first launch. That
    // exception lets a word equal to RESET_VALUE still produce a transfer after reset.
    candidate  = !in_changed && ((cfg_in != src_last_q) || !armed_q);
    launch     = candidate && (stab_cnt_q >= StableLaunch) && !busy_q;

    stab_cnt_d = stab_cnt_q;
    if (in_changed || launch) begin
      stab_cnt_d = '0;
    end else if (candidate && (stab_cnt_q < StableMax)) begin
      // Saturate so a word that settled during a transfer launches as soon as busy drops.
      stab_cnt_d = stab_cnt_q + 1'b1;
    end

    busy_d = busy_q;
    if (launch) begin
      busy_d = 1'b1;
    end else if (busy_q && (ack_s == req_tgl_q)) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_in_q   <= '0;
      src_last_q <= '0;
      hold_q     <= '0;
      stab_cnt_q <= '0;
      armed_q    <= 1'b0;
      req_tgl_q  <= 1'b0;
      busy_q     <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      cfg_in_q   <= cfg_in;
      stab_cnt_q <= stab_cnt_d;
      busy_q     <= busy_d;
      ack_sync_q <= {ack_sync_q[SYNC_DEPTH-2:0], ack_tgl_q};
      if (launch) begin
        hold_q     <= cfg_in;
        src_last_q <= cfg_in;
        armed_q    <= 1'b1;
        req_tgl_q  <= ~req_tgl_q;
      end
    end
  end

  assign src_busy = busy_q;

  // ---------------------------------------------------------------------------------------------
  // Destination domain (spi_clk)
  // ---------------------------------------------------------------------------------------------

  logic [SYNC_DEPTH-1:0] req_sync_q;
  logic                  req_s;
  logic [WIDTH-1:0]      stage_q;
  logic [WIDTH-1:0]      stage_d;
  logic [WIDTH-1:0]      cfg_out_q;
  logic [WIDTH-1:0]      cfg_out_d;
  logic                  ack_tgl_d;
  logic                  pending_q;
  logic                  pending_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  update_q;
  logic                  update_d;
  logic                  dropped_q;
  logic                  dropped_d;

  logic                  arrive;
  logic                  apply;

  assign req_s = req_sync_q[SYNC_DEPTH-1];

  always_comb begin
    arrive    = (req_s != ack_tgl_q);
    apply     = pending_q && apply_en && (!StrobeMode || apply_strobe);

    stage_d   = stage_q;
    cfg_out_d = cfg_out_q;
    ack_tgl_d = ack_tgl_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    dropped_d = 1'b0;

    // The apply uses the stage contents from before this edge. A simultaneous arrival therefore
    // applies the older word and leaves the newer one pending, with nothing lost.
    if (apply) begin
      cfg_out_d = stage_q;
      pending_d = 1'b0;
      valid_d   = 1'b1;
      update_d  = 1'b1;
    end

    if (arrive) begin
      // hold_q has been static since launch and stays so until this acknowledge returns.
      stage_d   = hold_q;
      ack_tgl_d = req_s;
      pending_d = 1'b1;
      dropped_d = pending_q && !apply;
    end
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      req_sync_q <= '0;
      ack_tgl_q  <= 1'b0;
      stage_q    <= '0;
      cfg_out_q  <= RESET_VALUE;
      pending_q  <= 1'b0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_DEPTH-2:0], req_tgl_q};
      ack_tgl_q  <= ack_tgl_d;
      stage_q    <= stage_d;
      cfg_out_q  <= cfg_out_d;
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      dropped_q  <= dropped_d;
    end
  end

  assign cfg_out     = cfg_out_q;
  assign cfg_valid   = valid_q;
  assign cfg_pending = pending_q;
  assign cfg_update  = update_q;
  assign cfg_dropped = dropped_q;

endmodule

// File: tb/tb_spi_cfg_cdc.sv
// Bench for spi_cfg_cdc. dut0 runs in immediate-apply mode and dut1 runs in strobe mode.
// spi_clk runs three times faster than clk.
module tb_spi_cfg_cdc;

  localparam int unsigned W  = 128;
  localparam int unsigned SD = 3;
  localparam int unsigned SC = 2;

  logic         clk = 1'b0;
  logic         spi_clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cfg_in0 = '0;
  logic [W-1:0] cfg_in1 = '0;
  logic         apply_en0 = 1'b1;
  logic         apply_en1 = 1'b1;
  logic         strobe0 = 1'b0;
  logic         strobe1 = 1'b0;

  logic [W-1:0] cfg_out0, cfg_out1;
  logic         busy0, busy1, valid0, valid1, pending0, pending1;
  logic         update0, update1, dropped0, dropped1;

  int n_tests = 0;
  int n_fail  = 0;

  spi_cfg_cdc #(.WIDTH(W), .SYNC_DEPTH(SD), .STABLE_COUNT(SC), .UPDATE_MODE(0)) dut0 (
    .spi_clk(spi_clk), .clk(clk), .rst(rst), .cfg_in(cfg_in0), .src_busy(busy0),
    .apply_en(apply_en0), .apply_strobe(strobe0), .cfg_out(cfg_out0), .cfg_valid(valid0),
    .cfg_pending(pending0), .cfg_update(update0), .cfg_dropped(dropped0)
  );

  spi_cfg_cdc #(.WIDTH(W), .SYNC_DEPTH(SD), .STABLE_COUNT(SC), .UPDATE_MODE(1)) dut1 (
    .spi_clk(spi_clk), .clk(clk), .rst(rst), .cfg_in(cfg_in1), .src_busy(busy1),
    .apply_en(apply_en1), .apply_strobe(strobe1), .cfg_out(cfg_out1), .cfg_valid(valid1),
    .cfg_pending(pending1), .cfg_update(update1), .cfg_dropped(dropped1)
  );

  initial forever #5 spi_clk = ~spi_clk;
  initial begin
    #2;
    forever #15 clk = ~clk;
  end

  // dut0 must ignore its strobe entirely, so drive it with noise.
  initial forever begin
    @(negedge spi_clk);
    strobe0 = 1'($urandom_range(0, 1));
  end

  // Record every word that appears with an update pulse, and every drop pulse.
  logic [W-1:0] obs0[$];
  int upd_cnt0 = 0, upd_cnt1 = 0, drop_cnt0 = 0, drop_cnt1 = 0;
  initial forever begin
    @(negedge spi_clk);
    if (update0) begin obs0.push_back(cfg_out0); upd_cnt0 = upd_cnt0 + 1; end
    if (update1) upd_cnt1 = upd_cnt1 + 1;
    if (dropped0) drop_cnt0 = drop_cnt0 + 1;
    if (dropped1) drop_cnt1 = drop_cnt1 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic spi_tick();
    @(negedge spi_clk);
    #1;
  endtask

  task automatic clk_tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pending(input bit which, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      spi_tick();
      if ((which ? pending1 : pending0) === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_upd0(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      spi_tick();
      if (upd_cnt0 >= target) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      clk_tick();
      if (busy0 === 1'b0 && busy1 === 1'b0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic strobe_pulse1();
    spi_tick();
    strobe1 = 1'b1;
    spi_tick();
    strobe1 = 1'b0;
  endtask

  logic [W-1:0] last0;  // word currently applied on dut0

  task automatic test_reset();
    bit ok;
    #20;
    n_tests++;
    if (cfg_out0 !== '0 || cfg_out1 !== '0) begin
      n_fail++;
      $display("FAIL reset_cfg_out: got %h/%h required 0", cfg_out0, cfg_out1);
    end
    n_tests++;
    if ({busy0, valid0, pending0, update0, dropped0, busy1, valid1, pending1, update1,
         dropped1} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0", {busy0, valid0, pending0, update0,
               dropped0, busy1, valid1, pending1, update1, dropped1});
    end
    @(negedge clk);
    rst = 1'b0;
    // A word equal to the reset value still travels after reset.
    wait_upd0(1, 300, ok);
    n_tests++;
    if (!ok || cfg_out0 !== '0 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_word: got ok=%0d valid=%b out=%h required 1 1 0",
               ok, valid0, cfg_out0);
    end
    wait_pending(1'b1, 300, ok);
    n_tests++;
    if (!ok || valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe_pending: got ok=%0d valid=%b required 1 0", ok, valid1);
    end
    strobe_pulse1();
    n_tests++;
    if (valid1 !== 1'b1 || pending1 !== 1'b0 || cfg_out1 !== '0) begin
      n_fail++;
      $display("FAIL reset_strobe_apply: got valid=%b pend=%b out=%h required 1 0 0",
               valid1, pending1, cfg_out1);
    end
    wait_idle(100, ok);
    last0 = '0;
  endtask

  task automatic test_basic();
    logic [W-1:0] exp;
    int n, m, base;
    bit ok;
    base = upd_cnt0;
    exp = rand_word();
    exp[7:0] = 8'hA5;
    clk_tick();
    cfg_in0 = exp;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (busy0 === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok || n != int'(SC) + 1) begin
      n_fail++;
      $display("FAIL basic_launch_edge: got busy after %0d edges required %0d", n, SC + 1);
    end
    m = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge spi_clk);
      #1;
      m++;
      if (pending0 === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok || m > int'(SD) + 2) begin
      n_fail++;
      $display("FAIL basic_pending_latency: got %0d spi edges required <= %0d", m, SD + 2);
    end
    @(posedge spi_clk);
    #1;
    n_tests++;
    if (update0 !== 1'b1 || cfg_out0 !== exp || pending0 !== 1'b0 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_apply: got upd=%b out=%h pend=%b required 1 %h 0", update0,
               cfg_out0, pending0, exp);
    end
    ok = 1'b0;
    for (int i = 0; i < 2 * (int'(SD) + 2); i++) begin
      clk_tick();
      if (busy0 === 1'b0) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_busy_clear: got busy=%b required 0", busy0);
    end
    repeat (4) spi_tick();
    n_tests++;
    if (upd_cnt0 != base + 1) begin
      n_fail++;
      $display("FAIL basic_update_count: got %0d required %0d", upd_cnt0 - base, 1);
    end
    last0 = exp;
  endtask

  task automatic test_glitch();
    logic [W-1:0] exp;
    int base;
    bit ok;
    base = upd_cnt0;
    exp = W'(8'h55);
    for (int i = 0; i < 3; i++) begin
      clk_tick();
      cfg_in0 = rand_word();
    end
    clk_tick();
    cfg_in0 = exp;
    wait_upd0(base + 1, 300, ok);
    repeat (60) spi_tick();
    n_tests++;
    if (!ok || upd_cnt0 != base + 1) begin
      n_fail++;
      $display("FAIL glitch_transfers: got %0d required 1", upd_cnt0 - base);
    end
    n_tests++;
    if (cfg_out0 !== exp || obs0[$] !== exp) begin
      n_fail++;
      $display("FAIL glitch_value: got %h required %h", cfg_out0, exp);
    end
    last0 = exp;
  endtask

  task automatic test_strobe();
    logic [W-1:0] exp;
    int base;
    bit ok;
    base = upd_cnt1;
    exp = W'(8'h11);
    clk_tick();
    cfg_in1 = exp;
    wait_pending(1'b1, 300, ok);
    repeat (10) spi_tick();
    n_tests++;
    if (!ok || pending1 !== 1'b1 || cfg_out1 !== '0 || upd_cnt1 != base) begin
      n_fail++;
      $display("FAIL strobe_hold: got pend=%b out=%h required 1 0", pending1, cfg_out1);
    end
    strobe_pulse1();
    n_tests++;
    if (cfg_out1 !== exp || pending1 !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_apply: got out=%h pend=%b required %h 0", cfg_out1, pending1, exp);
    end
    strobe_pulse1();  // nothing pending: no effect
    repeat (3) spi_tick();
    n_tests++;
    if (upd_cnt1 != base + 1 || cfg_out1 !== exp) begin
      n_fail++;
      $display("FAIL strobe_idle: got %0d updates required 1", upd_cnt1 - base);
    end
  endtask

  task automatic test_overwrite();
    logic [W-1:0] a, b;
    int dbase;
    bit ok;
    dbase = drop_cnt1;
    a = rand_word();
    b = W'(8'h22);
    clk_tick();
    cfg_in1 = a;
    wait_pending(1'b1, 300, ok);
    clk_tick();
    cfg_in1 = b;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      spi_tick();
      if (drop_cnt1 > dbase) begin ok = 1'b1; break; end
    end
    repeat (10) spi_tick();
    n_tests++;
    if (!ok || drop_cnt1 != dbase + 1) begin
      n_fail++;
      $display("FAIL overwrite_drop: got %0d drops required 1", drop_cnt1 - dbase);
    end
    n_tests++;
    if (cfg_out1 !== W'(8'h11) || pending1 !== 1'b1) begin
      n_fail++;
      $display("FAIL overwrite_hold: got out=%h pend=%b required 11 1", cfg_out1, pending1);
    end
    strobe_pulse1();
    n_tests++;
    if (cfg_out1 !== b || pending1 !== 1'b0) begin
      n_fail++;
      $display("FAIL overwrite_apply: got %h required %h", cfg_out1, b);
    end
  endtask

  task automatic test_gating_collision();
    logic [W-1:0] w1, w2;
    int base, dbase;
    bit ok;
    base = upd_cnt0;
    dbase = drop_cnt0;
    w1 = rand_word();
    w2 = rand_word();
    spi_tick();
    apply_en0 = 1'b0;
    clk_tick();
    cfg_in0 = w1;
    wait_pending(1'b0, 300, ok);
    repeat (10) spi_tick();
    n_tests++;
    if (!ok || cfg_out0 !== last0 || upd_cnt0 != base || pending0 !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_no_apply: got out=%h pend=%b required %h 1", cfg_out0, pending0,
               last0);
    end
    clk_tick();
    cfg_in0 = w2;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      spi_tick();
      if (dut0.arrive === 1'b1) begin apply_en0 = 1'b1; ok = 1'b1; break; end
    end
    spi_tick();
    n_tests++;
    if (!ok || cfg_out0 !== w1 || pending0 !== 1'b1 || update0 !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_first: got out=%h pend=%b required %h 1", cfg_out0, pending0, w1);
    end
    spi_tick();
    n_tests++;
    if (cfg_out0 !== w2 || pending0 !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_second: got out=%h pend=%b required %h 0", cfg_out0, pending0, w2);
    end
    repeat (3) spi_tick();
    n_tests++;
    if (drop_cnt0 != dbase || upd_cnt0 != base + 2) begin
      n_fail++;
      $display("FAIL collide_counts: got drops=%0d upds=%0d required 0 2", drop_cnt0 - dbase,
               upd_cnt0 - base);
    end
    last0 = w2;
  endtask

  // Reference: every word held long enough is applied once and in order, no glitch word (held
  // at most SC edges) ever appears, and nothing is dropped.
  task automatic test_random_stream();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w;
    int start, dbase;
    bit ok;
    start = obs0.size();
    dbase = drop_cnt0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        clk_tick();
        cfg_in0 = rand_word();
        repeat ($urandom_range(1, SC) - 1) clk_tick();
      end
      clk_tick();
      w = rand_word();
      cfg_in0 = w;
      exp_q.push_back(w);
      wait_upd0(start + i + 1, 500, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL stream_timeout: word %0d got no update required one", i);
      end
    end
    repeat (40) spi_tick();
    n_tests++;
    if (obs0.size() != start + exp_q.size() || drop_cnt0 != dbase) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words %0d drops required %0d 0",
               obs0.size() - start, drop_cnt0 - dbase, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_tests++;
      if (start + k >= obs0.size() || obs0[start + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stream_word%0d: got %h required %h", k,
                 (start + k < obs0.size()) ? obs0[start + k] : '0, exp_q[k]);
      end
    end
    last0 = w;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    clk_tick();
    cfg_in0 = rand_word();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy0 === 1'b1) begin ok = 1'b1; break; end
    end
    rst = 1'b1;
    cfg_in0 = '0;
    cfg_in1 = '0;
    #1;
    n_tests++;
    if (!ok || cfg_out0 !== '0 || valid0 !== 1'b0 || busy0 !== 1'b0 || pending0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_dut0: got out=%h valid=%b busy=%b required 0 0 0", cfg_out0,
               valid0, busy0);
    end
    n_tests++;
    if (cfg_out1 !== '0 || valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_dut1: got out=%h valid=%b required 0 0", cfg_out1, valid1);
    end
    repeat (3) @(negedge clk);
    obs0.delete();
    base = upd_cnt0;
    rst = 1'b0;
    wait_upd0(base + 1, 300, ok);
    repeat (60) spi_tick();
    n_tests++;
    if (!ok || obs0.size() != 1 || cfg_out0 !== '0 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_after: got %0d words out=%h valid=%b required 1 0 1",
               obs0.size(), cfg_out0, valid0);
    end
    n_tests++;
    if (obs0.size() > 0 && obs0[0] !== '0) begin
      n_fail++;
      $display("FAIL midreset_stale: got %h required 0", obs0[0]);
    end
  endtask

  initial begin
    bit ok;
    test_reset();
    test_basic();
    wait_idle(100, ok);
    test_glitch();
    wait_idle(100, ok);
    test_strobe();
    wait_idle(100, ok);
    test_overwrite();
    wait_idle(100, ok);
    test_gating_collision();
    wait_idle(100, ok);
    test_random_stream();
    wait_idle(100, ok);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cfg_cdc.md
# spi_cfg_cdc

Parametrised configuration-word clock-domain crossing between the AXI configuration domain (`clk`) and the SPI core domain (`spi_clk`). A packed configuration word of arbitrary width is debounced in the source domain and carried across with a toggle request/acknowledge handshake, so the bus is never sampled mid-change. In the destination domain the word is staged and applied either immediately or on a caller-supplied strobe, for example at a DAC frame boundary. It replaces per-field synchronizers with one coherent multi-bit transfer.

## Interface
- `WIDTH`, 128: packed configuration word width in bits, ≥1.
- `SYNC_DEPTH`, 3: flop stages per toggle synchronizer, ≥2.
- `STABLE_COUNT`, 2: consecutive unchanged `clk` edges required before launch, ≥1.
- `UPDATE_MODE`, 0: 0 applies as soon as allowed; 1 applies only on `apply_strobe`.
- `RESET_VALUE`, {WIDTH{1'b0}}: reset value of `cfg_out`.
- `spi_clk`  in  1  destination clock.
- `clk`  in  1  source (AXI) clock.
- `rst`  in  1  reset, asynchronous, active-high; clears both domains.
- `cfg_in`  in  WIDTH  packed configuration word, `clk` domain.
- `src_busy`  out  1  transfer in flight, `clk` domain.
- `apply_en`  in  1  apply permitted, `spi_clk` domain.
- `apply_strobe`  in  1  apply point when UPDATE_MODE=1, `spi_clk` domain.
- `cfg_out`  out  WIDTH  applied configuration word.
- `cfg_valid`  out  1  sticky; at least one word has been applied since reset.
- `cfg_pending`  out  1  staged word is awaiting apply.
- `cfg_update`  out  1  one-cycle pulse on the edge `cfg_out` loads.
- `cfg_dropped`  out  1  one-cycle pulse when a pending staged word is overwritten unapplied.

## Operation
- Source registers: `cfg_in_d`, `src_last`, `stab_cnt`, `armed`, `hold`, `req_tgl`, and the ack synchronizer.
- Candidate condition: `cfg_in == cfg_in_d`, and either `cfg_in != src_last` or `armed == 0`.
- `stab_cnt` increments on each edge where the candidate condition holds. It clears on any edge where `cfg_in != cfg_in_d`.
- Launch occurs on the edge where `stab_cnt` reaches STABLE_COUNT while `src_busy == 0`. At launch: `hold <= cfg_in`, `src_last <= cfg_in`, `armed <= 1`, `req_tgl` flips, `src_busy <= 1`, `stab_cnt <= 0`.
- A change seen while `src_busy == 1` waits. It launches after busy clears, provided it is still stable. Intermediate values are lost; the latest value wins.
- `hold` is written only at launch, so it is static for the whole time the destination may sample it.
- `src_busy` clears when the synchronized `ack_tgl` equals `req_tgl`.
- Destination: `req_tgl` passes through SYNC_DEPTH flops to give `req_s`.
- When `req_s != ack_tgl`: `stage <= hold`, `ack_tgl <= req_s`, `cfg_pending <= 1`. If `cfg_pending` was already 1 and no apply occurs on that edge, `cfg_dropped` pulses.
- Apply condition: `cfg_pending && apply_en && (UPDATE_MODE == 0 || apply_strobe)`. On apply: `cfg_out <= stage`, `cfg_pending <= 0`, `cfg_update` pulses, `cfg_valid <= 1`.
- Arrival and apply on the same edge: `cfg_out` takes the old `stage`, the new word loads into `stage`, `cfg_pending` stays 1, and there is no drop pulse.
- `apply_strobe` is ignored when UPDATE_MODE=0. A strobe with no pending word does nothing.

## Timing
- Reset values: `cfg_out` = RESET_VALUE; all other outputs 0; `stage`, `hold`, `src_last`, `stab_cnt`, `req_tgl`, `ack_tgl`, synchronizers all 0; `armed` 0.
- Because `armed` resets to 0, the first stable word after reset always launches, even if it equals RESET_VALUE.
- Source latency: `cfg_in` is sampled at edge 0, then stable through edges 1..STABLE_COUNT. Launch happens at edge STABLE_COUNT, and `src_busy` is high from the next cycle.
- Destination latency: `cfg_pending` rises within SYNC_DEPTH+2 `spi_clk` edges of launch.
- With UPDATE_MODE=0 and `apply_en` high, `cfg_out` updates exactly 1 `spi_clk` edge after `cfg_pending` rises.
- `src_busy` round trip: at most (SYNC_DEPTH+2) `spi_clk` plus (SYNC_DEPTH+2) `clk` cycles.
- Reset mid-transfer: the transfer is abandoned and both domains return to reset values immediately. No stale word may be applied after release.
- Clock ratio: any ratio is valid. Neither domain relies on a frequency assumption.

## Test plan
- **Basic transfer:** reset, then `cfg_in=0x…A5` held (WIDTH=128, UPDATE_MODE=0, `apply_en=1`) → `src_busy` pulses high; `cfg_out=0x…A5`, `cfg_valid=1`, one `cfg_update` pulse within the latency bound; `src_busy` returns to 0.
- **Glitch filter:** `cfg_in` changes on each of 3 consecutive `clk` edges, then holds 0x55 (STABLE_COUNT=2) → exactly one transfer; `cfg_out=0x55`; no intermediate value appears.
- **Strobe mode:** UPDATE_MODE=1, deliver 0x11 → `cfg_pending=1` and `cfg_out` unchanged until `apply_strobe`; on the strobe edge `cfg_out=0x11`, `cfg_pending=0`.
- **Overwrite:** UPDATE_MODE=1, deliver 0x11 then 0x22 with no strobe → one `cfg_dropped` pulse; the next strobe gives `cfg_out=0x22`.
- **Apply gating and same-edge collision:** `apply_en=0` with a word delivered → no apply. Then raise `apply_en` on the same `spi_clk` edge a second word arrives → `cfg_out`=first word, `cfg_pending` stays 1; next edge `cfg_out`=second word.
- **Reset:** assert `rst` while `src_busy=1`, `spi_clk`:`clk` = 3:1 → `cfg_out`=RESET_VALUE, `cfg_valid=0`. After release with `cfg_in`=RESET_VALUE held, one transfer still occurs and `cfg_valid=1`.
